seq_game_engine: RTL and testbench

//  Parametrised engine for the mini-games, generalising the hard-coded GAME1..GAME3 chains.

---
 rtl/seq_game_engine.sv | 169 ++++++++++++++++
 tb/tb_seq_game_engine.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_game_engine.sv
// seq_game_engine: plays NUM_GAMES pattern sequences in order,
// with per-step timeout, lives and a pre-empt abort.
module seq_game_engine #(
  parameter int NUM_GAMES  = 3,
  parameter int SEQ_LEN    = 3,
  parameter int IN_W       = 13,
  parameter int STEP_TICKS = 0,
  parameter int LIVES_INIT = 3
) (
  input  logic                                   Clk,
  input  logic                                   Reset,
  input  logic                                   clear,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic                                   tick,
  input  logic [IN_W-1:0]                        in_vec,
  input  logic [NUM_GAMES*SEQ_LEN*IN_W-1:0]      patterns,
  output logic                                   busy,
  output logic [$clog2(NUM_GAMES+1)-1:0]         game_idx,
  output logic [$clog2(SEQ_LEN)-1:0]             step_idx,
  output logic [2:0]                             lives,
  output logic                                   done,
  output logic                                   fail,
  output logic                                   aborted,
  output logic                                   all_done
);

  localparam int GW = $clog2(NUM_GAMES+1);
  localparam int SW = $clog2(SEQ_LEN);
  localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [TW-1:0] TLAST = TW'(STEP_TICKS-1);
  localparam logic [2:0]    LINIT = 3'(LIVES_INIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_STEP,
    S_REL
  } state_t;

  state_t          state_q;
  logic [GW-1:0]   game_q;
  logic [SW-1:0]   step_q;
  logic [2:0]      lives_q;
  logic [TW-1:0]   timer_q;
  logic            done_q;
  logic            fail_q;
  logic            abort_q;

  logic [IN_W-1:0] pat_p;
  logic [IN_W-1:0] pat_q;
  logic            all_done_w;
  logic            in_zero;
  logic            match;
  logic            illegal;
  logic            last_step;
  logic            timeout;

  // Select the current target pattern and the one before it.
  always_comb begin
    pat_p = '0;
    pat_q = '0;
    for (int g = 0; g < NUM_GAMES; g++) begin
      for (int k = 0; k < SEQ_LEN; k++) begin
        if (game_q == GW'(g) && step_q == SW'(k))
          pat_p = patterns[(g*SEQ_LEN+k)*IN_W +: IN_W];
      end
      for (int k = 0; k < SEQ_LEN-1; k++) begin
        if (game_q == GW'(g) && step_q == SW'(k+1))
          pat_q = patterns[(g*SEQ_LEN+k)*IN_W +: IN_W];
      end
    end
  end

  assign all_done_w = (game_q == GW'(NUM_GAMES));
  assign in_zero    = (in_vec == '0);
  assign match      = (in_vec == pat_p);
  assign illegal    = |(in_vec & ~(pat_p | pat_q));
  assign last_step  = (step_q == SW'(SEQ_LEN-1));
  assign timeout    = (STEP_TICKS != 0) && tick
                      && (timer_q == TLAST);

  // Game sequencing FSM with registered event pulses.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      game_q  <= '0;
      step_q  <= '0;
      lives_q <= LINIT;
      timer_q <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      abort_q <= 1'b0;
      if (clear) begin
        state_q <= S_IDLE;
        game_q  <= '0;
        step_q  <= '0;
        lives_q <= LINIT;
        timer_q <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start && lives_q != 3'd0 && !all_done_w)
              state_q <= S_ARM;
          end
          S_ARM: begin
            if (abort) begin
              state_q <= S_IDLE;
              abort_q <= 1'b1;
            end else if (in_zero) begin
              state_q <= S_STEP;
              step_q  <= '0;
              timer_q <= '0;
            end
          end
          S_STEP: begin
            if (abort) begin
              state_q <= S_IDLE;
              step_q  <= '0;
              abort_q <= 1'b1;
            end else if (match) begin
              if (last_step) begin
                state_q <= S_REL;
              end else begin
                step_q  <= step_q + SW'(1);
                timer_q <= '0;
              end
            end else if (illegal || timeout) begin
              fail_q  <= 1'b1;
              state_q <= S_IDLE;
              step_q  <= '0;
              if (lives_q != 3'd0)
                lives_q <= lives_q - 3'd1;
            end else if (tick && STEP_TICKS != 0) begin
              timer_q <= timer_q + TW'(1);
            end
          end
          S_REL: begin
            if (abort) begin
              state_q <= S_IDLE;
              step_q  <= '0;
              abort_q <= 1'b1;
            end else if (in_zero) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
              game_q  <= game_q + GW'(1);
              step_q  <= '0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign game_idx = game_q;
  assign step_idx = step_q;
  assign lives    = lives_q;
  assign done     = done_q;
  assign fail     = fail_q;
  assign aborted  = abort_q;
  assign all_done = all_done_w;

endmodule

// File: tb/tb_seq_game_engine.sv
// tb_seq_game_engine: directed scenarios plus randomized run
// against a rule-level reference model.
module tb_seq_game_engine;

  localparam int NG = 3;
  localparam int SL = 3;
  localparam int IW = 13;
  localparam int ST = 2;
  localparam int LI = 3;

  logic            Clk = 1'b0;
  logic            Reset = 1'b0;
  logic            clear = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            tick = 1'b0;
  logic [IW-1:0]   in_vec = '0;
  logic [NG*SL*IW-1:0] pat_vec;
  logic            busy;
  logic [1:0]      game_idx;
  logic [1:0]      step_idx;
  logic [2:0]      lives;
  logic            done;
  logic            fail;
  logic            aborted;
  logic            all_done;

  logic [IW-1:0]   pats [NG][SL];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: phase 0 idle,1 waiting for release,2 playing,3 final release
  int m_ph, m_g, m_k, m_lives, m_t;
  bit m_done, m_fail, m_ab;

  seq_game_engine #(
    .NUM_GAMES(NG), .SEQ_LEN(SL), .IN_W(IW),
    .STEP_TICKS(ST), .LIVES_INIT(LI)
  ) dut (
    .Clk(Clk), .Reset(Reset), .clear(clear),
    .start(start), .abort(abort), .tick(tick),
    .in_vec(in_vec), .patterns(pat_vec),
    .busy(busy), .game_idx(game_idx),
    .step_idx(step_idx), .lives(lives),
    .done(done), .fail(fail), .aborted(aborted),
    .all_done(all_done)
  );

  always #5 Clk = ~Clk;

  function automatic logic [11:0] dut_v();
    return {busy, game_idx, step_idx, lives,
            done, fail, aborted, all_done};
  endfunction

  function automatic logic [11:0] mod_v();
    return {m_ph != 0, 2'(m_g), 2'(m_k), 3'(m_lives),
            m_done, m_fail, m_ab, m_g == NG};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_g = 0; m_k = 0; m_lives = LI; m_t = 0;
    m_done = 0; m_fail = 0; m_ab = 0;
  endtask

  task automatic model_fail();
    m_fail = 1;
    if (m_lives > 0) m_lives--;
    m_ph = 0;
    m_k = 0;
  endtask

  task automatic model_edge();
    logic [IW-1:0] p, q;
    m_done = 0; m_fail = 0; m_ab = 0;
    if (clear) begin
      model_reset();
      return;
    end
    case (m_ph)
      0: if (start && m_lives > 0 && m_g < NG) m_ph = 1;
      1: begin
        if (abort) begin m_ph = 0; m_ab = 1; end
        else if (in_vec == 0) begin m_ph = 2; m_k = 0; m_t = 0; end
      end
      2: begin
        p = pats[m_g][m_k];
        q = '0;
        if (m_k > 0) q = pats[m_g][m_k-1];
        if (abort) begin
          m_ph = 0; m_k = 0; m_ab = 1;
        end else if (in_vec == p) begin
          if (m_k < SL-1) begin m_k++; m_t = 0; end
          else m_ph = 3;
        end else if ((in_vec & ~(p | q)) != 0) begin
          model_fail();
        end else if (tick) begin
          m_t++;
          if (ST != 0 && m_t == ST) model_fail();
        end
      end
      default: begin
        if (abort) begin
          m_ph = 0; m_k = 0; m_ab = 1;
        end else if (in_vec == 0) begin
          m_done = 1; m_g++; m_k = 0; m_ph = 0;
        end
      end
    endcase
  endtask

  task automatic cyc();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    clear = 0; start = 0; abort = 0; tick = 0; in_vec = '0;
  endtask

  task automatic do_clear();
    idle_in();
    clear = 1;
    cyc();
    clear = 0;
  endtask

  task automatic test_reset();
    idle_in();
    Reset = 1;
    #3;
    model_reset();
    n_tests++;
    if (dut_v() !== 12'b0_00_00_011_0000) begin
      n_fail++;
      $display("FAIL reset got %b exp %b", dut_v(), 12'b0_00_00_011_0000);
    end
    @(negedge Clk);
    Reset = 0;
  endtask

  task automatic play_game(input int g, input string nm);
    start = 1;
    cyc();
    start = 0;
    in_vec = '0;
    cyc();
    for (int k = 0; k < SL; k++) begin
      in_vec = pats[g][k];
      cyc();
      n_tests++;
      if (dut_v() !== mod_v()) begin
        n_fail++;
        $display("FAIL %s step %0d got %h exp %h", nm, k, dut_v(), mod_v());
      end
    end
    in_vec = '0;
    cyc();
  endtask

  task automatic test_game0();
    do_clear();
    play_game(0, "game0");
    n_tests++;
    if (done !== 1'b1 || game_idx !== 2'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL game0_done got done=%b g=%0d busy=%b exp 1 1 0",
               done, game_idx, busy);
    end
    cyc();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL game0_pulse got done=%b exp 0", done);
    end
  endtask

  task automatic test_illegal();
    do_clear();
    start = 1; cyc(); start = 0;
    in_vec = '0; cyc();
    in_vec = 13'h001; cyc();
    in_vec = 13'h021; cyc();
    n_tests++;
    if (fail !== 1'b1 || lives !== 3'd2 || game_idx !== 2'd0 ||
        step_idx !== 2'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal got f=%b l=%0d g=%0d s=%0d b=%b exp 1 2 0 0 0",
               fail, lives, game_idx, step_idx, busy);
    end
    in_vec = '0;
  endtask

  task automatic test_timeout();
    do_clear();
    start = 1; cyc(); start = 0;
    in_vec = '0; cyc();
    tick = 1; cyc();
    n_tests++;
    if (fail !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_first got f=%b b=%b exp 0 1", fail, busy);
    end
    cyc();
    tick = 0;
    n_tests++;
    if (fail !== 1'b1 || lives !== 3'd2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout got f=%b l=%0d b=%b exp 1 2 0", fail, lives, busy);
    end
  endtask

  task automatic test_abort_last();
    do_clear();
    start = 1; cyc(); start = 0;
    in_vec = '0; cyc();
    in_vec = pats[0][0]; cyc();
    in_vec = pats[0][1]; cyc();
    in_vec = pats[0][2];
    abort = 1;
    cyc();
    abort = 0;
    n_tests++;
    if (aborted !== 1'b1 || done !== 1'b0 || lives !== 3'd3 ||
        busy !== 1'b0 || game_idx !== 2'd0 || step_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL abort_last got a=%b d=%b l=%0d b=%b g=%0d s=%0d",
               aborted, done, lives, busy, game_idx, step_idx);
    end
    in_vec = '0;
    cyc();
  endtask

  task automatic test_lives();
    do_clear();
    for (int i = 0; i < LI; i++) begin
      start = 1; cyc(); start = 0;
      in_vec = '0; cyc();
      in_vec = 13'h020; cyc();
      in_vec = '0;
    end
    n_tests++;
    if (lives !== 3'd0 || fail !== 1'b1) begin
      n_fail++;
      $display("FAIL lives_zero got l=%0d f=%b exp 0 1", lives, fail);
    end
    start = 1; cyc(); cyc(); start = 0;
    n_tests++;
    if (busy !== 1'b0 || lives !== 3'd0) begin
      n_fail++;
      $display("FAIL lives_start got b=%b l=%0d exp 0 0", busy, lives);
    end
    do_clear();
    n_tests++;
    if (lives !== 3'd3) begin
      n_fail++;
      $display("FAIL lives_clear got %0d exp 3", lives);
    end
  endtask

  task automatic test_all_done();
    do_clear();
    for (int g = 0; g < NG; g++) play_game(g, "all");
    n_tests++;
    if (all_done !== 1'b1 || game_idx !== 2'd3) begin
      n_fail++;
      $display("FAIL all_done got ad=%b g=%0d exp 1 3", all_done, game_idx);
    end
    start = 1; cyc(); cyc(); start = 0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL all_done_start got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    do_clear();
    start = 1; cyc(); start = 0;
    in_vec = '0; cyc();
    in_vec = pats[0][0]; cyc();
    Reset = 1;
    #2;
    model_reset();
    n_tests++;
    if (dut_v() !== 12'b0_00_00_011_0000) begin
      n_fail++;
      $display("FAIL reset_mid got %b exp %b", dut_v(), 12'b0_00_00_011_0000);
    end
    Reset = 0;
    idle_in();
  endtask

  task automatic test_random();
    int r;
    do_clear();
    for (int i = 0; i < 3000; i++) begin
      clear = ($urandom_range(0, 249) == 0);
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 39) == 0);
      tick  = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 99);
      if (m_g < NG && r < 60) in_vec = pats[m_g][m_k];
      else if (r < 75) in_vec = '0;
      else if (m_g < NG && m_k > 0 && r < 85) in_vec = pats[m_g][m_k-1];
      else if (m_g < NG && r < 95) in_vec = pats[m_g][m_k] & IW'($urandom);
      else in_vec = IW'($urandom);
      if (m_g == NG && $urandom_range(0, 9) == 0) clear = 1;
      cyc();
      n_tests++;
      if (dut_v() !== mod_v()) begin
        n_fail++;
        $display("FAIL random cyc %0d got %b exp %b", i, dut_v(), mod_v());
      end
    end
    idle_in();
  endtask

  initial begin
    pats[0][0] = 13'h001; pats[0][1] = 13'h003; pats[0][2] = 13'h007;
    pats[1][0] = 13'h100; pats[1][1] = 13'h180; pats[1][2] = 13'h1C0;
    pats[2][0] = 13'h1000; pats[2][1] = 13'h1001; pats[2][2] = 13'h0801;
    for (int g = 0; g < NG; g++)
      for (int k = 0; k < SL; k++)
        pat_vec[(g*SL+k)*IW +: IW] = pats[g][k];
    model_reset();
    test_reset();
    test_game0();
    test_illegal();
    test_timeout();
    test_abort_last();
    test_lives();
    test_all_done();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
